// File: rtl/mdio_receiver_pkg.sv
// Shared encodings for the clause-22 MDIO receiver: FSM states, opcodes and field widths.
package mdio_receiver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSt1,
    StHdr,
    StTaW,
    StWr,
    StTaR,
    StRd,
    StSkip
  } state_e;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam int unsigned HDR_BITS  = 12;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;
  localparam int unsigned SKIP_BITS = TA_BITS + DATA_BITS;

  // True when the bit counter sits on the final bit of a field of nbits.
  function automatic logic last_bit(logic [4:0] cnt, int unsigned nbits);
    return cnt == 5'(nbits - 1);
  endfunction

endpackage

// File: rtl/mdio_receiver_if.sv
// MDIO serial bus between the management controller (master) and this PHY receiver (slave).
interface mdio_receiver_if;
  logic mdc;
  logic mdio_oe;
  logic mdio_out;
  logic mdio_in;
  logic mdio_in_en;

  modport master (
    output mdc, mdio_oe, mdio_out,
    input  mdio_in, mdio_in_en
  );

  modport slave (
    input  mdc, mdio_oe, mdio_out,
    output mdio_in, mdio_in_en
  );
endinterface

// File: rtl/mdio_rx_shreg.sv
// mdc rising-edge detector, 16-bit shift register (parallel load for read data) and
// 5-bit bit counter with clear, all in the clk domain.
module mdio_rx_shreg
  import mdio_receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mdc,
  input  logic                 din,
  input  logic                 shift_en,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 cnt_inc,
  input  logic                 cnt_clr,
  output logic                 mdc_rise,
  output logic [DATA_BITS-1:0] sr,
  output logic [4:0]           cnt
);

  logic                 mdc_q;
  logic [DATA_BITS-1:0] sr_q;
  logic [4:0]           cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_q <= 1'b0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mdc_q <= mdc;
      if (load) begin
        sr_q <= load_data;
      end else if (shift_en) begin
        sr_q <= {sr_q[DATA_BITS-2:0], din};
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign mdc_rise = mdc & ~mdc_q;
  assign sr       = sr_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/mdio_receiver.sv
// PHY-side clause-22 MDIO frame receiver: decodes frames, strobes the register file and
// serialises read data. Optional PHYAD filtering is enabled by MDIO_PHYAD_FILTER_EN.
module mdio_receiver
  import mdio_receiver_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  mdio_receiver_if.slave       mdio,
  output logic [4:0]           reg_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_stb,
  output logic                 rd_req,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 frame_err
);

  state_e               state_q;
  logic                 rise;
  logic [DATA_BITS-1:0] sr;
  logic [4:0]           cnt;
  logic                 shift_en, cnt_inc, cnt_clr;
  logic                 rd_cap_q;
  logic                 mdio_in_q, mdio_in_en_q;
  logic [HDR_BITS-1:0]  hdr;
  logic [1:0]           hdr_op;
  logic [4:0]           hdr_phy, hdr_reg;
  logic                 phy_ok;

  mdio_rx_shreg u_shreg (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdio.mdc),
    .din       (mdio.mdio_out),
    .shift_en  (shift_en),
    .load      (rd_cap_q),
    .load_data (rd_data),
    .cnt_inc   (cnt_inc),
    .cnt_clr   (cnt_clr),
    .mdc_rise  (rise),
    .sr        (sr),
    .cnt       (cnt)
  );

  // Full header including the bit arriving in this rise cycle.
  assign hdr     = {sr[HDR_BITS-2:0], mdio.mdio_out};
  assign hdr_op  = hdr[11:10];
  assign hdr_phy = hdr[9:5];
  assign hdr_reg = hdr[4:0];

`ifdef MDIO_PHYAD_FILTER_EN
  assign phy_ok = (hdr_phy == PHY_ADDR);
`else
  assign phy_ok = 1'b1;
  logic unused_phy;
  assign unused_phy = ^{hdr_phy, PHY_ADDR};
`endif

  always_comb begin
    shift_en = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    if (rise) begin
      case (state_q)
        StSt1: cnt_clr = 1'b1;
        StHdr: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          cnt_clr  = last_bit(cnt, HDR_BITS);
        end
        StTaW: begin
          cnt_inc = 1'b1;
          cnt_clr = last_bit(cnt, TA_BITS);
        end
        StWr: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
        end
        // Second TA rise presents rd_data[15] and starts shifting out.
        StTaR: begin
          cnt_inc  = 1'b1;
          cnt_clr  = last_bit(cnt, TA_BITS);
          shift_en = last_bit(cnt, TA_BITS);
        end
        StRd: begin
          cnt_inc  = 1'b1;
          shift_en = ~last_bit(cnt, DATA_BITS);
        end
        StSkip:  cnt_inc = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      reg_addr     <= '0;
      wr_data      <= '0;
      wr_stb       <= 1'b0;
      rd_req       <= 1'b0;
      frame_err    <= 1'b0;
      rd_cap_q     <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_in_en_q <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;
      rd_cap_q  <= rd_req;
      if (rise) begin
        case (state_q)
          StIdle: begin
            if (mdio.mdio_oe && !mdio.mdio_out) state_q <= StSt1;
          end
          StSt1: begin
            if (mdio.mdio_oe && mdio.mdio_out) begin
              state_q <= StHdr;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end
          end
          StHdr: begin
            if (!mdio.mdio_oe) begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end else if (last_bit(cnt, HDR_BITS)) begin
              reg_addr <= hdr_reg;
              if (!phy_ok) begin
                state_q <= StSkip;
              end else if (hdr_op == OP_WR) begin
                state_q <= StTaW;
              end else if (hdr_op == OP_RD) begin
                rd_req  <= 1'b1;
                state_q <= StTaR;
              end else begin
                frame_err <= 1'b1;
                state_q   <= StIdle;
              end
            end
          end
          // Write turnaround must be 1 then 0.
          StTaW: begin
            if (!mdio.mdio_oe || (mdio.mdio_out != (cnt == 5'd0))) begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end else if (last_bit(cnt, TA_BITS)) begin
              state_q <= StWr;
            end
          end
          StWr: begin
            if (!mdio.mdio_oe) begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end else if (last_bit(cnt, DATA_BITS)) begin
              wr_data <= {sr[DATA_BITS-2:0], mdio.mdio_out};
              wr_stb  <= 1'b1;
              state_q <= StIdle;
            end
          end
          StTaR: begin
            if (last_bit(cnt, TA_BITS)) begin
              mdio_in_q <= sr[DATA_BITS-1];
              state_q   <= StRd;
            end else begin
              mdio_in_en_q <= 1'b1;
              mdio_in_q    <= 1'b0;
            end
          end
          StRd: begin
            if (last_bit(cnt, DATA_BITS)) begin
              mdio_in_en_q <= 1'b0;
              mdio_in_q    <= 1'b0;
              state_q      <= StIdle;
            end else begin
              mdio_in_q <= sr[DATA_BITS-1];
            end
          end
          StSkip: begin
            if (last_bit(cnt, SKIP_BITS)) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mdio.mdio_in    = mdio_in_q;
  assign mdio.mdio_in_en = mdio_in_en_q;

endmodule

// File: tb/tb_mdio_receiver.sv
// Directed bench for mdio_receiver: table of whole frames plus hand-written reset,
// back-to-back and error-timing sequences.
module tb_mdio_receiver;

`ifdef MDIO_PHYAD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        frame_err;

  mdio_receiver_if mdio ();

  mdio_receiver #(
    .PHY_ADDR (5'd3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mdio      (mdio),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          n_wr = 0, n_rd = 0, n_err = 0;
  logic [15:0] mon_wdata = '0;
  logic [4:0]  mon_waddr = '0, mon_raddr = '0;

  always @(posedge clk) begin
    if (wr_stb) begin
      n_wr      <= n_wr + 1;
      mon_wdata <= wr_data;
      mon_waddr <= reg_addr;
    end
    if (rd_req) begin
      n_rd      <= n_rd + 1;
      mon_raddr <= reg_addr;
    end
    if (frame_err) n_err <= n_err + 1;
  end

  int n_vec = 0;
  int n_bad = 0;
  int hp    = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mdc_cycle(input logic oe, input logic b, output logic en_s, output logic in_s);
    mdio.mdc      = 1'b0;
    mdio.mdio_oe  = oe;
    mdio.mdio_out = oe ? b : 1'b1;
    repeat (hp) @(posedge clk);
    #1;
    en_s     = mdio.mdio_in_en;
    in_s     = mdio.mdio_in;
    mdio.mdc = 1'b1;
    repeat (hp) @(posedge clk);
    #1;
  endtask

  // Drive nper mdc periods; the first non carry frame bits with mdio_oe=1.
  task automatic run_bits(input logic [31:0] f, input int non, input int nper,
                          output logic [32:0] en_v, output logic [32:0] in_v);
    en_v = '0;
    in_v = '0;
    for (int p = 0; p < nper; p++) begin
      logic b, e, i;
      if (p < 32) b = f[5'(31 - p)];
      else b = 1'b1;
      mdc_cycle(p < non, b, e, i);
      en_v[6'(p)] = e;
      in_v[6'(p)] = i;
    end
  endtask

  function automatic logic [31:0] mk(logic [1:0] op, logic [4:0] phy, logic [4:0] ra,
                                     logic [1:0] ta, logic [15:0] d);
    return {2'b01, op, phy, ra, ta, d};
  endfunction

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [15:0] rd;
    bit          is_rd;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [32:0] en_v, in_v, exp_en, exp_in;
    int w0, r0, e0;

    vecs[0]  = '{mk(2'b01, 5'd3, 5'd5,  2'b10, 16'hA5C3), 32, 16'h0000, 1'b0, 1, 0, 0,
                 5'd5, 16'hA5C3};
    vecs[1]  = '{mk(2'b10, 5'd3, 5'd5,  2'b11, 16'hFFFF), 14, 16'h1234, 1'b1, 0, 1, 0,
                 5'd5, 16'h0000};
    vecs[2]  = '{32'h0000_0000, 2, 16'h0000, 1'b0, 0, 0, 1, 5'd5, 16'h0000};
    vecs[3]  = '{mk(2'b01, 5'd3, 5'd7,  2'b10, 16'h0F0F), 32, 16'h0000, 1'b0, 1, 0, 0,
                 5'd7, 16'h0F0F};
    vecs[4]  = '{mk(2'b11, 5'd3, 5'd12, 2'b10, 16'h1111), 14, 16'h0000, 1'b0, 0, 0, 1,
                 5'd12, 16'h0000};
    vecs[5]  = '{mk(2'b00, 5'd3, 5'd13, 2'b10, 16'h2222), 14, 16'h0000, 1'b0, 0, 0, 1,
                 5'd13, 16'h0000};
    vecs[6]  = '{mk(2'b01, 5'd3, 5'd9,  2'b11, 16'h3333), 16, 16'h0000, 1'b0, 0, 0, 1,
                 5'd9, 16'h0000};
    vecs[7]  = '{mk(2'b01, 5'd3, 5'd10, 2'b10, 16'h4444), 20, 16'h0000, 1'b0, 0, 0, 1,
                 5'd10, 16'h0000};
    vecs[8]  = '{mk(2'b10, 5'd3, 5'd31, 2'b11, 16'hFFFF), 14, 16'h8001, 1'b1, 0, 1, 0,
                 5'd31, 16'h0000};
    vecs[9]  = '{mk(2'b01, 5'd3, 5'd0,  2'b10, 16'hFFFF), 32, 16'h0000, 1'b0, 1, 0, 0,
                 5'd0, 16'hFFFF};
    vecs[10] = '{mk(2'b01, 5'd4, 5'd6,  2'b10, 16'h5A5A), 32, 16'h0000, 1'b0,
                 FILT ? 0 : 1, 0, 0, 5'd6, 16'h5A5A};
    vecs[11] = '{mk(2'b10, 5'd4, 5'd2,  2'b11, 16'hFFFF), 14, 16'hBEEF, 1'b1, 0,
                 FILT ? 0 : 1, 0, 5'd2, 16'h0000};

    reset         = 1'b1;
    rd_data       = '0;
    mdio.mdc      = 1'b0;
    mdio.mdio_oe  = 1'b0;
    mdio.mdio_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({mdio.mdio_in, mdio.mdio_in_en, reg_addr, wr_data, wr_stb,
                                rd_req, frame_err}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++) begin
      w0      = n_wr;
      r0      = n_rd;
      e0      = n_err;
      rd_data = vecs[v].rd;
      run_bits(vecs[v].frame, vecs[v].nbits, 33, en_v, in_v);
      check($sformatf("v%0d_wr_stb_count", v), 64'(n_wr - w0), 64'(vecs[v].exp_wr));
      check($sformatf("v%0d_rd_req_count", v), 64'(n_rd - r0), 64'(vecs[v].exp_rd));
      check($sformatf("v%0d_frame_err_count", v), 64'(n_err - e0), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_reg_addr", v), 64'(reg_addr), 64'(vecs[v].exp_addr));
      if (vecs[v].exp_wr != 0) begin
        check($sformatf("v%0d_wr_data", v), 64'(mon_wdata), 64'(vecs[v].exp_wdata));
        check($sformatf("v%0d_wr_addr", v), 64'(mon_waddr), 64'(vecs[v].exp_addr));
      end
      if (vecs[v].exp_rd != 0)
        check($sformatf("v%0d_rd_addr", v), 64'(mon_raddr), 64'(vecs[v].exp_addr));
      exp_en = '0;
      exp_in = '0;
      if (vecs[v].is_rd && vecs[v].exp_rd != 0) begin
        for (int p = 15; p < 32; p++) exp_en[6'(p)] = 1'b1;
        for (int p = 16; p < 32; p++) exp_in[6'(p)] = vecs[v].rd[4'(31 - p)];
      end
      check($sformatf("v%0d_mdio_in_en_serial", v), 64'(en_v), 64'(exp_en));
      check($sformatf("v%0d_mdio_in_serial", v), 64'(in_v), 64'(exp_in));
    end

    // Reset after 20 bits of a write frame discards it; the next frame is served.
    w0 = n_wr;
    run_bits(mk(2'b01, 5'd3, 5'd20, 2'b10, 16'hDEAD), 20, 20, en_v, in_v);
    mdio.mdc     = 1'b0;
    mdio.mdio_oe = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_frame_outputs", 64'({mdio.mdio_in, mdio.mdio_in_en, reg_addr, wr_data,
                                          wr_stb, rd_req, frame_err}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_frame_no_wr", 64'(n_wr - w0), 64'd0);
    run_bits(mk(2'b01, 5'd3, 5'd4, 2'b10, 16'h1357), 32, 33, en_v, in_v);
    check("after_reset_wr_count", 64'(n_wr - w0), 64'd1);
    check("after_reset_wr_data", 64'(mon_wdata), 64'h1357);
    check("after_reset_reg_addr", 64'(reg_addr), 64'd4);

    // Fastest mdc (one clk per phase), two write frames back to back.
    hp = 1;
    w0 = n_wr;
    e0 = n_err;
    run_bits(mk(2'b01, 5'd3, 5'd17, 2'b10, 16'hC001), 32, 32, en_v, in_v);
    run_bits(mk(2'b01, 5'd3, 5'd18, 2'b10, 16'h0FF0), 32, 33, en_v, in_v);
    check("b2b_wr_count", 64'(n_wr - w0), 64'd2);
    check("b2b_wr_data", 64'(mon_wdata), 64'h0FF0);
    check("b2b_wr_addr", 64'(mon_waddr), 64'd18);
    check("b2b_no_err", 64'(n_err - e0), 64'd0);

    // frame_err is already out right after the second bad start bit.
    hp = 2;
    w0 = n_wr;
    r0 = n_rd;
    e0 = n_err;
    run_bits(32'h0000_0000, 2, 2, en_v, in_v);
    check("bad_start_err_after_bit2", 64'(n_err - e0), 64'd1);
    run_bits(32'h0000_0000, 0, 2, en_v, in_v);
    check("bad_start_no_strobes", 64'((n_wr - w0) + (n_rd - r0)), 64'd0);
    check("bad_start_single_err", 64'(n_err - e0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
